// File: rtl/config_pkg.sv
// Shared constants, FSM state type, header layout and fabric slice offsets
// for the configuration loader.
package config_pkg;

    localparam int unsigned CFG_NUM_WORDS = 23;
    localparam int unsigned CFG_WORD_W    = 32;
    localparam logic [15:0] CFG_MAGIC     = 16'hC0F6;

    typedef enum logic [1:0] {
        ST_HDR    = 2'd0,
        ST_DATA   = 2'd1,
        ST_CSUM   = 2'd2,
        ST_COMMIT = 2'd3
    } cfg_state_e;

    // Header word layout: magic in the upper half, word count in the lower half.
    typedef struct packed {
        logic [15:0] magic;
        logic [15:0] num_words;
    } cfg_hdr_t;

    // Bit offsets into the flat configuration bus, used by the fabric slicers.
    localparam int unsigned SB_COMMON_LSB = 0;     // word 0 [15:0]
    localparam int unsigned SB_BIT0_LSB   = 32;    // word 1 [15:0]
    localparam int unsigned SB_BIT1_LSB   = 64;    // word 2 [15:0]
    localparam int unsigned SB_W          = 16;
    localparam int unsigned LUT_A_LSB     = 96;    // words 3/4
    localparam int unsigned LUT_C_LSB     = 160;   // words 5/6
    localparam int unsigned LUT_MEM_W     = 33;
    localparam int unsigned LUT_B_LSB     = 224;   // words 7..22
    localparam int unsigned LUT_B_STRIDE  = 64;    // two words per LUT-B
    localparam int unsigned LUT_B_COUNT   = 8;

    function automatic logic hdr_match(input cfg_hdr_t    hdr,
                                       input logic [15:0] magic,
                                       input logic [15:0] num_words);
        return (hdr.magic == magic) && (hdr.num_words == num_words);
    endfunction

endpackage

// File: rtl/cfg_shadow_buf.sv
// Shadow word buffer: NUM_WORDS x 32-bit registers written by index, cleared
// as a whole, read out as one flat bus (word i at bits [32*i+31:32*i]).
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of all words
//   wr_en      : write wr_data into word wr_idx
//   rd_flat    : all words, flat
module cfg_shadow_buf #(
    parameter int unsigned NUM_WORDS = 23,
    parameter int unsigned IDX_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [31:0]             wr_data,
    output logic [NUM_WORDS*32-1:0] rd_flat
);

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
        logic [31:0] word_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (clr) begin
                word_q <= '0;
            end else if (wr_en && (wr_idx == IDX_W'(g))) begin
                word_q <= wr_data;
            end
        end

        assign rd_flat[32*g +: 32] = word_q;
    end

endmodule

// File: rtl/config_loader.sv
// Framed configuration loader: header/length/XOR-checksum check, shadow
// assembly, atomic commit of the whole frame to cfg_frame.
//   clock, reset_n     : clock, async active-low reset
//   in_data/valid/ready: configuration word stream
//   cfg_abort          : drop the frame in progress
//   cfg_frame/valid    : committed configuration
//   cfg_done           : one-cycle commit pulse
//   cfg_err            : sticky error, cleared on commit
module config_loader
    import config_pkg::*;
#(
    parameter int unsigned NUM_WORDS = CFG_NUM_WORDS,
    parameter logic [15:0] MAGIC     = CFG_MAGIC
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [31:0]             in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    cfg_abort,
    output logic [NUM_WORDS*32-1:0] cfg_frame,
    output logic                    cfg_valid,
    output logic                    cfg_done,
    output logic                    cfg_err
);

    localparam int unsigned CNT_W   = $clog2(NUM_WORDS);
    localparam int unsigned FRAME_W = NUM_WORDS * CFG_WORD_W;

    cfg_state_e         state_q;
    cfg_state_e         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        csum_q;
    logic [FRAME_W-1:0] shadow_flat;

    logic accept;
    logic hdr_ok;
    logic last_word;
    logic csum_ok;
    logic shadow_wr;
    logic shadow_clr;

    // Abort blocks acceptance so a word presented alongside it is dropped.
    assign in_ready   = (state_q != ST_COMMIT) && !cfg_abort;
    assign accept     = in_valid && in_ready;
    assign hdr_ok     = hdr_match(cfg_hdr_t'(in_data), MAGIC, 16'(NUM_WORDS));
    assign last_word  = (cnt_q == CNT_W'(NUM_WORDS - 1));
    assign csum_ok    = (in_data == csum_q);
    assign shadow_wr  = accept && (state_q == ST_DATA);
    assign shadow_clr = cfg_abort || (accept && (state_q == ST_CSUM) && !csum_ok);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        if (cfg_abort) begin
            state_d = ST_HDR;
        end else begin
            unique case (state_q)
                ST_HDR:    if (accept && hdr_ok)    state_d = ST_DATA;
                ST_DATA:   if (accept && last_word) state_d = ST_CSUM;
                ST_CSUM:   if (accept)              state_d = csum_ok ? ST_COMMIT : ST_HDR;
                ST_COMMIT:                          state_d = ST_HDR;
                default:                            state_d = ST_HDR;
            endcase
        end
    end

    // Word counter and running XOR over data words.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            csum_q <= '0;
        end else if (cfg_abort) begin
            cnt_q  <= '0;
            csum_q <= '0;
        end else if (accept && (state_q == ST_HDR) && hdr_ok) begin
            cnt_q  <= '0;
            csum_q <= '0;
        end else if (shadow_wr) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            csum_q <= csum_q ^ in_data;
        end
    end

    cfg_shadow_buf #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (CNT_W)
    ) u_shadow (
        .clk     (clock),
        .rst_n   (reset_n),
        .clr     (shadow_clr),
        .wr_en   (shadow_wr),
        .wr_idx  (cnt_q),
        .wr_data (in_data),
        .rd_flat (shadow_flat)
    );

    // Committed frame and status flags; an abort in COMMIT cancels the commit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cfg_frame <= '0;
            cfg_valid <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if ((state_q == ST_COMMIT) && !cfg_abort) begin
                cfg_frame <= shadow_flat;
                cfg_valid <= 1'b1;
                cfg_done  <= 1'b1;
                cfg_err   <= 1'b0;
            end else if (accept && (state_q == ST_HDR) && !hdr_ok) begin
                cfg_err <= 1'b1;
            end else if (accept && (state_q == ST_CSUM) && !csum_ok) begin
                cfg_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Randomized self-checking bench for config_loader against a frame-level model.
module tb_config_loader;
    import config_pkg::*;

    localparam int unsigned NW = CFG_NUM_WORDS;
    localparam logic [31:0] GOOD_HDR = 32'hC0F60017;

    logic                clock;
    logic                reset_n;
    logic [31:0]         in_data;
    logic                in_valid;
    logic                in_ready;
    logic                cfg_abort;
    logic [NW*32-1:0]    cfg_frame;
    logic                cfg_valid;
    logic                cfg_done;
    logic                cfg_err;

    config_loader dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cfg_abort (cfg_abort),
        .cfg_frame (cfg_frame),
        .cfg_valid (cfg_valid),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the fabric should currently see.
    logic [31:0] exp_frame [NW];
    logic        exp_valid;
    logic        exp_err;
    logic [31:0] tx_data   [NW];

    bit mon_en = 1'b0;
    int ready_low_cnt = 0;

    always @(negedge clock) begin
        if (mon_en && !in_ready && !cfg_abort) ready_low_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) exp_frame[i] = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid"}, 32'(cfg_valid), 32'(exp_valid));
        check({tag, "_err"},   32'(cfg_err),   32'(exp_err));
        for (int i = 0; i < NW; i++)
            check($sformatf("%s_w%0d", tag, i), cfg_frame[32*i +: 32], exp_frame[i]);
    endtask

    // Present one word after a gap; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] w, input int gap);
        int b;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (gap) @(negedge clock);
        in_data  = w;
        in_valid = 1'b1;
        b = 0;
        while (!in_ready && b < 20) begin
            @(negedge clock);
            b++;
        end
        if (b >= 20) check("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] data_xor();
        logic [31:0] x = '0;
        for (int i = 0; i < NW; i++) x ^= tx_data[i];
        return x;
    endfunction

    // Good header + tx_data + csum; checks commit timing or error behaviour.
    task automatic run_frame(input string tag, input logic [31:0] csum, input int max_gap);
        bit good;
        bit done_seen;
        good = (csum == data_xor());
        send_word(GOOD_HDR, $urandom_range(max_gap, 0));
        for (int i = 0; i < NW; i++) send_word(tx_data[i], $urandom_range(max_gap, 0));
        send_word(csum, $urandom_range(max_gap, 0));
        if (good) begin
            check({tag, "_done_early"}, 32'(cfg_done), 32'd0);
            check({tag, "_ready_commit"}, 32'(in_ready), 32'd0);
            @(posedge clock); #1;
            check({tag, "_done_pulse"}, 32'(cfg_done), 32'd1);
            for (int i = 0; i < NW; i++) exp_frame[i] = tx_data[i];
            exp_valid = 1'b1;
            exp_err   = 1'b0;
            check_state(tag);
            @(posedge clock); #1;
            check({tag, "_done_end"}, 32'(cfg_done), 32'd0);
        end else begin
            exp_err = 1'b1;
            check({tag, "_ready_after_bad"}, 32'(in_ready), 32'd1);
            done_seen = 1'b0;
            repeat (4) begin
                if (cfg_done) done_seen = 1'b1;
                @(posedge clock); #1;
            end
            check({tag, "_no_done"}, 32'(done_seen), 32'd0);
            check_state(tag);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NW; i++) tx_data[i] = 32'(i) * 32'h01010101;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NW; i++) tx_data[i] = $urandom;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        cfg_abort = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_done",  32'(cfg_done), 32'd0);
        check_state("reset");

        // Good frame with the ramp pattern.
        fill_ramp();
        check("ramp_csum_model", data_xor(), 32'h17171717);
        run_frame("good", 32'h17171717, 0);
        check("good_w5", cfg_frame[32*5 +: 32], 32'h05050505);

        // Bad checksum, new data: active frame must stay the ramp.
        fill_random();
        run_frame("badcsum", data_xor() ^ 32'h1, 0);
        fill_ramp();
        run_frame("badcsum_same", 32'h17171716, 0);

        // Bad header, then a good frame clears the error.
        send_word(32'hDEAD0017, 0);
        exp_err = 1'b1;
        check("badhdr_err", 32'(cfg_err), 32'd1);
        send_word(32'hC0F60016, 1);
        check_state("badlen");
        fill_random();
        run_frame("after_badhdr", data_xor(), 0);

        // Abort with in_valid after 10 data words.
        fill_random();
        send_word(GOOD_HDR, 0);
        for (int i = 0; i < 10; i++) send_word(tx_data[i], 0);
        @(negedge clock);
        in_data   = 32'h12345678;
        in_valid  = 1'b1;
        cfg_abort = 1'b1;
        #1;
        check("abort_ready", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        cfg_abort = 1'b0;
        in_valid  = 1'b0;
        check_state("abort");
        // Abort in HDR with a bad word presented: must not be seen as an error.
        @(negedge clock);
        in_data   = 32'hDEAD0017;
        in_valid  = 1'b1;
        cfg_abort = 1'b1;
        @(posedge clock); #1;
        cfg_abort = 1'b0;
        in_valid  = 1'b0;
        check("abort_hdr_err", 32'(cfg_err), 32'd0);
        run_frame("after_abort", data_xor(), 0);

        // Throttled ramp frame: same result, in_ready low only in COMMIT.
        fill_ramp();
        ready_low_cnt = 0;
        mon_en = 1'b1;
        run_frame("throttle", 32'h17171717, 5);
        mon_en = 1'b0;
        check("throttle_ready_low", 32'(ready_low_cnt), 32'd1);

        // Reset during DATA after a committed frame.
        fill_random();
        send_word(GOOD_HDR, 0);
        for (int i = 0; i < 5; i++) send_word(tx_data[i], 0);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_state("midreset");
        check("midreset_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        run_frame("after_reset", data_xor(), 0);

        // Random frames, random good/bad checksum and gaps.
        for (int k = 0; k < 6; k++) begin
            fill_random();
            if ($urandom_range(1, 0) == 1)
                run_frame($sformatf("rnd%0d", k), data_xor(), 2);
            else
                run_frame($sformatf("rnd%0d", k), data_xor() ^ (32'd1 << $urandom_range(31, 0)), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/config_loader.md
# config_loader

Configuration front-end for the soft fabric. It accepts a framed stream of 32-bit configuration words and checks the header, length and XOR checksum. Words are assembled in a shadow buffer, and the complete frame is committed atomically to a flat output bus. The downstream fabric (switch-block `configure` fields and LUT `mem` fields of the shift-register tile) slices that bus, so it never sees a partial or corrupt configuration.

## Interface
- `NUM_WORDS`, 23: data words per frame.
- `MAGIC`, 16'hC0F6: required value of header bits [31:16].
- `clock` in 1: single clock; all state changes on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_data` in 32: configuration stream word.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader can accept a word; a word transfers on a rising edge when `in_valid && in_ready`.
- `cfg_abort` in 1: synchronous abort of the frame in progress.
- `cfg_frame` out NUM_WORDS*32: active configuration; word i occupies bits [32*i+31 : 32*i].
- `cfg_valid` out 1: `cfg_frame` holds a committed frame.
- `cfg_done` out 1: one-cycle pulse on commit.
- `cfg_err` out 1: sticky error flag.

## Operation
- FSM states: HDR, DATA, CSUM, COMMIT.
- **HDR**
  - Accepted word with [31:16]==MAGIC and [15:0]==NUM_WORDS: clear word counter and running XOR, go to DATA.
  - Any other accepted word: discarded, `cfg_err` set, stay in HDR.
- **DATA**
  - Each accepted word is written to `shadow[cnt]`, XORed into the running checksum, and `cnt` increments.
  - After word NUM_WORDS-1 is accepted, go to CSUM.
- **CSUM**
  - Accepted word equal to the running XOR: go to COMMIT.
  - Mismatch: set `cfg_err`, shadow discarded, go to HDR, active frame untouched.
- **COMMIT** (exactly one cycle)
  - `cfg_frame` <= shadow, `cfg_valid` <= 1, `cfg_done` pulses, `cfg_err` cleared, go to HDR.
- **`cfg_abort`**
  - In any state, it returns the FSM to HDR and discards the shadow.
  - It does not set `cfg_err` and does not alter `cfg_frame` or `cfg_valid`.
- A new load never disturbs the active frame. `cfg_frame` and `cfg_valid` hold their previous values until the next COMMIT.
- Counter width is $clog2(NUM_WORDS). The checksum is a plain 32-bit XOR over data words only; header and checksum words are excluded.

## Timing
- **Reset values:** state=HDR, `in_ready`=1, `cfg_frame`=0, `cfg_valid`=0, `cfg_done`=0, `cfg_err`=0, shadow=0, cnt=0.
- **`in_ready`:** decoded combinationally from state and `cfg_abort`.
  - Low in COMMIT and whenever `cfg_abort`=1.
  - High otherwise.
  - Full throughput of one word per cycle in HDR, DATA and CSUM.
- **Commit latency:**
  - Checksum accepted at edge N puts the FSM in COMMIT for cycle N..N+1.
  - `cfg_frame`, `cfg_valid` and `cfg_done` update at edge N+1.
  - `cfg_done` is high for cycle N+1..N+2 only.
- **Minimum frame:** NUM_WORDS+2 accepted words plus one COMMIT cycle. Back-to-back frames have one bubble.
- **Abort with `in_valid` in the same cycle:** abort wins and the word is not accepted.
- **Reset asserted mid-frame:** all outputs return to reset values immediately (asynchronously), including a previously committed frame.
- **`in_valid` low:** no state change; idle gaps of any length are legal mid-frame.

## Structure
- Package `config_pkg` holds:
  - `CFG_MAGIC` and the FSM state enum.
  - Field offset constants for the fabric slicing:
    - word 0 [15:0]: common switch block.
    - words 1 and 2 [15:0]: per-bit switch blocks.
    - words 3/4: LUT-A 33-bit mem.
    - words 5/6: LUT-C 33-bit mem.
    - words 7..22: per-bit LUT-B mem, two words each.
- One sub-module, `cfg_shadow_buf`: NUM_WORDS×32 write-indexed register array with a flat read-out.
- The FSM, counter and checksum stay in `config_loader`.

## Test plan
- **Good frame:** send header 0xC0F60017, data words i*0x01010101 for i=0..22, checksum 0x17171717.
  - `cfg_done` pulses one cycle after the checksum is accepted.
  - `cfg_valid`=1 and `cfg_frame` word 5 = 0x05050505.
- **Bad checksum:** same frame with checksum 0x17171716.
  - `cfg_err`=1, `cfg_done` never pulses.
  - `cfg_frame` and `cfg_valid` unchanged from the prior state.
- **Bad header:** send 0xDEAD0017, then a good frame.
  - `cfg_err`=1 after the first word, then cleared on the good commit.
  - The good frame is committed.
- **Abort:** assert `cfg_abort` together with `in_valid` after 10 data words, then send a full good frame.
  - The word presented with the abort is not accepted.
  - `cfg_err` stays 0 and the second frame commits correctly.
- **Throttling:** randomize `in_valid` gaps (0–5 cycles) during a good frame.
  - Identical `cfg_frame` to the no-gap case.
  - `in_ready` low only in the COMMIT cycle.
- **Reset mid-frame:** pulse `reset_n` low during DATA after a previous successful commit.
  - `cfg_valid`, `cfg_frame` and `cfg_err` go to 0 immediately.
  - The next good frame loads normally.
